// File: rtl/nios2os_nios2_qsys_mul_seq_pkg.sv
// Shared constants, state encoding and partial-product placement for the sequential multiplier.
package nios2os_nios2_qsys_mul_seq_pkg;

   // Operation encoding on req_op
   localparam logic [1:0] OpMul    = 2'b00;
   localparam logic [1:0] OpMulxss = 2'b01;
   localparam logic [1:0] OpMulxsu = 2'b10;
   localparam logic [1:0] OpMulxuu = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StDrain,
      StCorr,
      StResp
   } state_e;

   localparam int unsigned IssueCycles = 4;
   localparam int unsigned CorrCycles  = 1;

   // DRAIN waits for the last partial product to leave the sub-multiplier
   function automatic int unsigned drain_cycles(input int unsigned mult_pipe);
      return mult_pipe;
   endfunction

   // Issue index -> shifted partial product: 0:lo*lo, 1:hi*lo, 2:lo*hi, 3:hi*hi
   function automatic logic [63:0] place_pp(input logic [1:0] idx, input logic [31:0] p);
      logic [63:0] r;
      unique case (idx)
         2'd0:       r = {32'd0, p};
         2'd1, 2'd2: r = {16'd0, p, 16'd0};
         default:    r = {p, 32'd0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/nios2os_nios2_qsys_mul16_cell.sv
// 16x16 unsigned multiplier with MULT_PIPE register stages on the product.
module nios2os_nios2_qsys_mul16_cell #(
   parameter int unsigned MULT_PIPE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] prod;
   logic [31:0] stage_q [MULT_PIPE];

   assign prod = a * b;

   // Product pipeline; cleared on reset so nothing stale survives an abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MULT_PIPE; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= prod;
         for (int unsigned i = 1; i < MULT_PIPE; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign p = stage_q[MULT_PIPE-1];

endmodule

// File: rtl/nios2os_nios2_qsys_mul_seq.sv
// Sequential 32x32 multiplier built from four 16x16 partial products plus sign correction.
module nios2os_nios2_qsys_mul_seq
   import nios2os_nios2_qsys_mul_seq_pkg::*;
#(
   parameter int unsigned MULT_PIPE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        busy
);

   localparam logic [1:0] IssueLast = 2'(IssueCycles - 1);
   localparam logic [1:0] DrainLast = 2'(drain_cycles(MULT_PIPE) - 1);

   state_e         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [1:0]     op_q;
   logic [31:0]    src1_q, src2_q;
   logic [63:0]    acc_q, acc_d;
   logic           accept, issue;
   logic [31:0]    corr;
   logic [15:0]    mul_a, mul_b;
   logic [31:0]    mul_p;

   // Tags travel alongside the sub-multiplier so each product knows its shift
   logic [MULT_PIPE-1:0] tag_vld_q;
   logic [1:0]           tag_idx_q [MULT_PIPE];

   // Issue index bit 0 picks the src1 half, bit 1 the src2 half
   assign mul_a = cnt_q[0] ? src1_q[31:16] : src1_q[15:0];
   assign mul_b = cnt_q[1] ? src2_q[31:16] : src2_q[15:0];

   nios2os_nios2_qsys_mul16_cell #(
      .MULT_PIPE(MULT_PIPE)
   ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .a      (mul_a),
      .b      (mul_b),
      .p      (mul_p)
   );

   // Sequencing: accept, four issue cycles, drain the pipe, correct, respond
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               accept  = 1'b1;
               cnt_d   = 2'd0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            issue = 1'b1;
            if (cnt_q == IssueLast) begin
               cnt_d   = 2'd0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StDrain: begin
            if (cnt_q == DrainLast) begin
               cnt_d   = 2'd0;
               state_d = StCorr;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StCorr: state_d = StResp;
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Signed fix-up of the unsigned high word: subtract the other operand per negative input
   always_comb begin
      corr = '0;
      if ((op_q == OpMulxss || op_q == OpMulxsu) && src1_q[31]) corr = src2_q;
      if (op_q == OpMulxss && src2_q[31]) corr = corr + src1_q;
   end

   // Accumulator: clear on accept, add arriving products, then apply correction
   always_comb begin
      acc_d = acc_q;
      if (accept) begin
         acc_d = '0;
      end else if (state_q == StCorr) begin
         acc_d[63:32] = acc_q[63:32] - corr;
      end else if (tag_vld_q[MULT_PIPE-1]) begin
         acc_d = acc_q + place_pp(tag_idx_q[MULT_PIPE-1], mul_p);
      end
   end

   // State, counters, operands and accumulator
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (accept) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
         end
      end
   end

   // Tag pipeline, same depth as the sub-multiplier
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld_q <= '0;
         for (int unsigned i = 0; i < MULT_PIPE; i++) tag_idx_q[i] <= '0;
      end else begin
         tag_vld_q[0] <= issue;
         tag_idx_q[0] <= cnt_q;
         for (int unsigned i = 1; i < MULT_PIPE; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign rsp_valid  = (state_q == StResp);
   assign rsp_result = !rsp_valid      ? 32'd0 :
                       (op_q == OpMul) ? acc_q[31:0] : acc_q[63:32];

endmodule

// File: tb/tb_nios2os_nios2_qsys_mul_seq.sv
// Scoreboard bench: two DUTs (MULT_PIPE 1 and 2), directed vectors, backpressure and reset abort.
module tb_nios2os_nios2_qsys_mul_seq;
   import nios2os_nios2_qsys_mul_seq_pkg::*;

   typedef struct {
      logic [31:0] res;
      int unsigned acc_cyc;
      int unsigned lat;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [1:0]  req_op     [2];
   logic [31:0] req_src1   [2];
   logic [31:0] req_src2   [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_result [2];
   logic        busy       [2];

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];
   logic        vld_prev [2];
   exp_t        mon_e;
   bit          mon_have;
   vec_t        vecs [10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nios2os_nios2_qsys_mul_seq #(.MULT_PIPE(1)) u_dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_op    (req_op[0]),
      .req_src1  (req_src1[0]),
      .req_src2  (req_src2[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_ready (rsp_ready[0]),
      .rsp_result(rsp_result[0]),
      .busy      (busy[0])
   );

   nios2os_nios2_qsys_mul_seq #(.MULT_PIPE(2)) u_dut2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_op    (req_op[1]),
      .req_src1  (req_src1[1]),
      .req_src2  (req_src2[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_ready (rsp_ready[1]),
      .rsp_result(rsp_result[1]),
      .busy      (busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented response against the scoreboard head
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mon_have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
         if (mon_have) mon_e = (d == 0) ? sb0[0] : sb1[0];
         if (!rsp_valid[d]) begin
            chk($sformatf("d%0d_idle_result_zero", d), rsp_result[d], 32'd0);
         end else if (!mon_have) begin
            chk($sformatf("d%0d_unexpected_rsp", d), rsp_result[d], 32'hxxxx_xxxx);
         end else begin
            if (!vld_prev[d]) chk($sformatf("d%0d_latency", d), cyc - mon_e.acc_cyc, mon_e.lat);
            chk($sformatf("d%0d_result", d), rsp_result[d], mon_e.res);
            if (rsp_ready[d]) begin
               if (d == 0) void'(sb0.pop_front());
               else        void'(sb1.pop_front());
            end
         end
         vld_prev[d] = rsp_valid[d];
      end
   end

   task automatic do_req(input int d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input bit push);
      exp_t e;
      bit   ok = 1'b0;
      @(posedge clk); #1;
      req_valid[d] = 1'b1;
      req_op[d]    = op;
      req_src1[d]  = a;
      req_src2[d]  = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk($sformatf("d%0d_accept_timeout", d), 32'd0, 32'd1);
      end else if (push) begin
         e.res     = res;
         e.acc_cyc = cyc;
         e.lat     = 6 + d + 1;
         if (d == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      @(posedge clk); #1;
      // Scramble the request ports to show the captured operands are used
      req_valid[d] = 1'b0;
      req_op[d]    = 2'($urandom);
      req_src1[d]  = $urandom;
      req_src2[d]  = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (sb0.size() == 0 && sb1.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_empty", 32'(sb0.size() + sb1.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input int d, input string tag);
      chk($sformatf("d%0d_%s_req_ready", d, tag), 32'(req_ready[d]), 32'd1);
      chk($sformatf("d%0d_%s_rsp_valid", d, tag), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("d%0d_%s_rsp_result", d, tag), rsp_result[d], 32'd0);
      chk($sformatf("d%0d_%s_busy", d, tag), 32'(busy[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_op[d]    = 2'd0;
         req_src1[d]  = '0;
         req_src2[d]  = '0;
         rsp_ready[d] = 1'b1;
         vld_prev[d]  = 1'b0;
      end
      vecs[0] = '{OpMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1] = '{OpMul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[2] = '{OpMul,    32'h0001_2345, 32'h0001_0000, 32'h2345_0000};
      vecs[3] = '{OpMulxss, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[4] = '{OpMulxss, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5] = '{OpMulxsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[6] = '{OpMulxsu, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[7] = '{OpMulxss, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      vecs[8] = '{OpMulxuu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      vecs[9] = '{OpMul,    32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs(0, "por");
      chk_reset_outputs(1, "por");
      reset_n = 1'b1;

      // MULT_PIPE=1 vectors
      for (int i = 0; i < 10; i++) do_req(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
      drain();

      // Backpressure: result held, second request ignored until handshake
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      do_req(0, OpMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", 32'(ok), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         req_valid[0] = 1'b1;
         req_op[0]    = OpMul;
         req_src1[0]  = 32'd2;
         req_src2[0]  = 32'd3;
         @(negedge clk);
         chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
         chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
         chk("bp_busy", 32'(busy[0]), 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      do_req(0, OpMul, 32'd2, 32'd3, 32'd6, 1'b1);
      drain();

      // Reset during ISSUE cycle 2 aborts without a stale response
      do_req(0, OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
      @(posedge clk); #1;
      chk("abort_busy_before_reset", 32'(busy[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs(0, "abort");
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_req(0, OpMulxuu, 32'd3, 32'd5, 32'd0, 1'b1);
      do_req(0, OpMul, 32'd3, 32'd5, 32'd15, 1'b1);
      drain();

      // MULT_PIPE=2 vectors
      for (int i = 0; i < 10; i++) do_req(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
